// File: rtl/spi_ram_ctrl.sv
// SPI command decoder and RAM arbiter; SPI data ops have strict priority over the local host port.
// Optional macro SPI_ADDR_AUTOINC_EN: post-increment wr_addr/rd_addr each time an SPI data op issues.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 cmd_drop,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, SPI_ACC, SPI_RDW, HOST_ACC, HOST_RDW} state_t;

  localparam logic [ADDR_SIZE-1:0] LP_ADDR_MASK = ADDR_SIZE'(MEM_DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state;
  state_t                 w_next;

  logic [ADDR_SIZE-1:0]   r_wr_addr;
  logic [ADDR_SIZE-1:0]   r_rd_addr;
  logic                   r_pend_vld;
  logic                   r_pend_rd;
  logic [ADDR_SIZE-1:0]   r_pend_addr;
  logic [7:0]             r_pend_data;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic [7:0]             r_host_rdata;
  logic                   r_cmd_drop;

  logic                   w_is_data;
  logic                   w_pend_free;
  logic                   w_pend_load;
  logic                   w_mem_en;
  logic                   w_mem_we;
  logic [ADDR_SIZE-1:0]   w_mem_addr;
  logic [7:0]             w_mem_wdata;
  logic                   w_host_gnt;
  logic                   w_host_rvalid;

  // The ACC states are resolved combinationally out of IDLE, so an access issues
  // in the same cycle the arbiter sees the request; only the RDW states are registered.
  always_comb begin
    w_state       = r_state;
    w_next        = IDLE;
    w_mem_en      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_host_gnt    = 1'b0;
    w_host_rvalid = 1'b0;
    if (rst) begin
      w_state = IDLE;
    end else if (r_state == IDLE) begin
      if (r_pend_vld)    w_state = SPI_ACC;
      else if (host_req) w_state = HOST_ACC;
    end
    case (w_state)
      SPI_ACC: begin
        w_mem_en    = 1'b1;
        w_mem_we    = ~r_pend_rd;
        w_mem_addr  = r_pend_addr;
        w_mem_wdata = r_pend_data;
        w_next      = r_pend_rd ? SPI_RDW : IDLE;
      end
      HOST_ACC: begin
        w_mem_en    = 1'b1;
        w_mem_we    = host_we;
        w_mem_addr  = host_addr;
        w_mem_wdata = host_wdata;
        w_host_gnt  = 1'b1;
        w_next      = host_we ? IDLE : HOST_RDW;
      end
      HOST_RDW: begin
        w_host_rvalid = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The pending slot frees in the cycle it issues, so a word arriving then is kept.
  assign w_is_data   = rx_valid & rx_data[8];
  assign w_pend_free = ~r_pend_vld | (w_state == SPI_ACC);
  assign w_pend_load = w_is_data & w_pend_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_host_rdata <= '0;
      r_cmd_drop   <= 1'b0;
    end else begin
      r_cmd_drop <= w_is_data & ~w_pend_free;
      if (w_pend_load) begin
        r_pend_vld  <= 1'b1;
        r_pend_rd   <= rx_data[9];
        r_pend_addr <= rx_data[9] ? r_rd_addr : r_wr_addr;
        r_pend_data <= rx_data[7:0];
      end else if (w_state == SPI_ACC) begin
        r_pend_vld <= 1'b0;
      end
`ifdef SPI_ADDR_AUTOINC_EN
      if (w_state == SPI_ACC) begin
        if (r_pend_rd) r_rd_addr <= (r_rd_addr + ADDR_SIZE'(1)) & LP_ADDR_MASK;
        else           r_wr_addr <= (r_wr_addr + ADDR_SIZE'(1)) & LP_ADDR_MASK;
      end
`endif
      // An explicit address command overrides a same-cycle increment.
      if (rx_valid && rx_data[9:8] == 2'b00) r_wr_addr <= rx_data[ADDR_SIZE-1:0];
      if (rx_valid && rx_data[9:8] == 2'b10) r_rd_addr <= rx_data[ADDR_SIZE-1:0];
      if (w_state == SPI_RDW) begin
        r_tx_data  <= mem_rdata;
        r_tx_valid <= 1'b1;
      end else if (rx_valid) begin
        r_tx_valid <= 1'b0;
      end
      if (w_state == HOST_RDW) r_host_rdata <= mem_rdata;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign host_gnt    = w_host_gnt;
  assign host_rvalid = w_host_rvalid;
  assign host_rdata  = (w_state == HOST_RDW) ? mem_rdata : r_host_rdata;
  assign cmd_drop    = r_cmd_drop;
  assign mem_en      = w_mem_en;
  assign mem_we      = w_mem_we;
  assign mem_addr    = w_mem_addr & LP_ADDR_MASK;
  assign mem_wdata   = w_mem_wdata;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: directed timing cases plus randomized SPI/host traffic against a
// behavioural memory/address model.
module tb_spi_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       cmd_drop;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int drop_cnt = 0;
  int wr_cnt = 0;

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr;
  logic [7:0] ref_rd;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .cmd_drop(cmd_drop),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, cleared by the bench reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (cmd_drop)         drop_cnt++;
    if (mem_en && mem_we) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic spi(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k, d0, w0, seen;
    logic [7:0] a, d, e;
    int op;

    // ---------------- reset ----------------
    rst = 1'b1;
    host_req = 1'b1;
    host_we = 1'b0;
    repeat (3) cyc();
    at_neg();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_host", {host_gnt, host_rvalid, host_rdata}, 0);
    check("rst_cmd_drop", cmd_drop, 0);
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    cyc();
    host_req = 1'b0;
    rst = 1'b0;
    cyc();

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_wr = 8'h00;
    ref_rd = 8'h00;
    for (int n = 0; n < 160; n++) begin
      op = $urandom_range(0, 5);
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      case (op)
        0: begin spi({2'b00, a}); ref_wr = a; end
        1: begin spi({2'b10, a}); ref_rd = a; end
        2: begin
          spi({2'b01, d});
          ref_mem[ref_wr] = d;
`ifdef SPI_ADDR_AUTOINC_EN
          ref_wr = ref_wr + 8'd1;
`endif
        end
        3: begin
          e = ref_mem[ref_rd];
`ifdef SPI_ADDR_AUTOINC_EN
          ref_rd = ref_rd + 8'd1;
`endif
          spi({2'b11, d});
          k = 0;
          while (k < 10) begin
            at_neg();
            if (tx_valid) break;
            cyc();
            k++;
          end
          check("rnd_rd_latency", k, 2);
          check("rnd_rd_data", tx_data, e);
        end
        4: begin
          host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
          at_neg();
          check("rnd_hw_gnt", host_gnt, 1);
          cyc();
          host_req = 1'b0;
          ref_mem[a] = d;
        end
        default: begin
          e = ref_mem[a];
          host_req = 1'b1; host_we = 1'b0; host_addr = a;
          at_neg();
          check("rnd_hr_gnt", host_gnt, 1);
          cyc();
          host_req = 1'b0;
          at_neg();
          check("rnd_hr_rvalid", host_rvalid, 1);
          check("rnd_hr_rdata", host_rdata, e);
        end
      endcase
      repeat (12) cyc();
    end
    for (int i = 0; i < 256; i++) check($sformatf("rnd_ram[%0h]", i), ram[i], ref_mem[i]);
    check("rnd_no_drop", drop_cnt, 0);

    // ---------------- SPI write ----------------
    spi(10'h025);
    at_neg();
    check("addr_cmd_no_mem", mem_en, 0);
    repeat (11) cyc();
    spi(10'h1A7);
    at_neg();
    check("wr_mem_en_we", {mem_en, mem_we}, 2'b11);
    check("wr_mem_addr", mem_addr, 8'h25);
    check("wr_mem_wdata", mem_wdata, 8'hA7);
    repeat (12) cyc();

    // ---------------- SPI read ----------------
    spi(10'h225);
    repeat (12) cyc();
    spi(10'h300);
    at_neg();
    check("rd_issue", {mem_en, mem_we, mem_addr}, {2'b10, 8'h25});
    cyc(); at_neg();
    check("rd_tx_valid_c2", tx_valid, 0);
    cyc(); at_neg();
    check("rd_tx_valid_c3", tx_valid, 1);
    check("rd_tx_data", tx_data, 8'hA7);
    repeat (6) cyc(); at_neg();
    check("rd_tx_valid_hold", tx_valid, 1);
    cyc();
    spi(10'h040);
    at_neg();
    check("rd_tx_valid_clr", tx_valid, 0);
    check("rd_tx_data_hold", tx_data, 8'hA7);
    repeat (12) cyc();

    // ---------------- host read ----------------
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h25;
    at_neg();
    check("hr_gnt", {host_gnt, mem_en, mem_we, mem_addr}, {3'b110, 8'h25});
    cyc();
    host_req = 1'b0;
    at_neg();
    check("hr_rvalid", {host_rvalid, host_gnt}, 2'b10);
    check("hr_rdata", host_rdata, 8'hA7);
    cyc(); at_neg();
    check("hr_rvalid_pulse", host_rvalid, 0);
    repeat (3) cyc();

    // ---------------- host/SPI collision and dropped command ----------------
    spi(10'h025);
    repeat (12) cyc();
    d0 = drop_cnt;
    w0 = wr_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h25;
    rx_data = 10'h155; rx_valid = 1'b1;
    at_neg();
    check("col_host_first", {host_gnt, mem_we, mem_addr}, {2'b10, 8'h25});
    cyc();
    host_req = 1'b0;
    rx_data = 10'h166; rx_valid = 1'b1;
    at_neg();
    check("col_host_rdata", {host_rvalid, host_rdata}, {1'b1, 8'hA7});
    check("col_mem_idle", mem_en, 0);
    cyc();
    rx_valid = 1'b0;
    at_neg();
    check("col_spi_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h25, 8'h55});
    check("col_cmd_drop", cmd_drop, 1);
    cyc(); at_neg();
    check("col_cmd_drop_pulse", cmd_drop, 0);
    repeat (12) cyc();
    check("col_drop_count", drop_cnt - d0, 1);
    check("col_write_count", wr_cnt - w0, 1);
    check("col_ram25", ram[8'h25], 8'h55);

    // ---------------- host write with same-cycle SPI read ----------------
    spi(10'h225);
    repeat (12) cyc();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h5A;
    rx_data = 10'h300; rx_valid = 1'b1;
    at_neg();
    check("hw_gnt", {host_gnt, mem_en, mem_we, mem_addr}, {3'b111, 8'h30});
    cyc();
    host_req = 1'b0; rx_valid = 1'b0;
    at_neg();
    check("hw_spi_next", {mem_en, mem_we, mem_addr}, {2'b10, 8'h25});
    cyc(); cyc(); at_neg();
    check("hw_spi_tx", {tx_valid, tx_data}, {1'b1, 8'h55});
    repeat (12) cyc();
    check("hw_ram30", ram[8'h30], 8'h5A);

    // ---------------- address streaming / wrap ----------------
    spi(10'h0FF);
    repeat (12) cyc();
    spi(10'h111);
    repeat (12) cyc();
    spi(10'h122);
    repeat (12) cyc();
`ifdef SPI_ADDR_AUTOINC_EN
    check("inc_ramFF", ram[8'hFF], 8'h11);
    check("inc_ram00", ram[8'h00], 8'h22);
`else
    check("noinc_ramFF", ram[8'hFF], 8'h22);
`endif

    // ---------------- reset during SPI_RDW ----------------
    spi(10'h225);
    repeat (12) cyc();
    spi(10'h300);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    at_neg();
    check("rstrdw_tx_valid", tx_valid, 0);
    check("rstrdw_mem_en", mem_en, 0);
    seen = 0;
    repeat (4) begin
      cyc(); at_neg();
      if (tx_valid || mem_en) seen++;
    end
    check("rstrdw_quiet", seen, 0);
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    at_neg();
    check("rstrdw_idle_gnt", host_gnt, 1);
    cyc();
    host_req = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
